block_threshold_unit: RTL and testbench
=======================================

# block_threshold_unit

Streaming, multi-channel block-pruning threshold generator for the attention datapath. It accumulates per-channel min/max/sum over a run of tile scores delivered by valid/ready. It then computes each channel's mean with a shared sequential divider and interpolates a threshold between min, mean and max at a programmable eighth-step pruning ratio. The result is presented on a valid/ready output to the block-pruning comparator stage.

## Interface
Parameters:
- DATA_W, 16, unsigned tile score width (fixed-point, FRAC_BITS fractional)
- FRAC_BITS, 8, fractional bits of scores and thresholds (carried through, no rescaling)
- CHANNELS, 2, independent score channels per beat
- MAX_TILES, 64, maximum tiles per run
- derived CNT_W = clog2(MAX_TILES+1); SUM_W = DATA_W + CNT_W

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE only
- ratio  in  4  pruning ratio in eighths, 0..8; sampled with start; values >8 saturate to 8
- clear  in  1  synchronous abort to IDLE, highest priority after reset
- tile_valid  in  1  score beat valid
- tile_ready  out  1  high in ACCUM only
- tile_last  in  1  final beat of run, qualified by valid&ready
- tile_score  in  CHANNELS*DATA_W  channel c in bits [c*DATA_W +: DATA_W]
- thresh_valid  out  1  result valid, held until accepted
- thresh_ready  in  1  downstream accept
- threshold  out  CHANNELS*DATA_W  per-channel thresholds, same packing
- tile_count  out  CNT_W  tiles accumulated in the run
- overflow  out  1  run ended by MAX_TILES without tile_last; valid with thresh_valid

## Operation
- States: IDLE, ACCUM, DIVIDE, INTERP, DONE.
- IDLE: start -> ACCUM; latch ratio (saturated); clear min to all-ones, max/sum/count to 0.
- ACCUM, per accepted beat: min=min(min,s), max=max(max,s), sum+=s, count+=1. Leave to DIVIDE if tile_last, or if count reaches MAX_TILES (set overflow if tile_last is low).
- DIVIDE: mean_c = floor(sum_c/count), channels serially (0 first), restoring divide, one quotient bit per cycle, SUM_W cycles per channel. Quotient truncated to DATA_W; it fits because mean ≤ max.
- INTERP, one cycle, k=ratio:
  - k≤4: thr = min + (((mean-min)*k) >> 2)
  - k>4: thr = mean + (((max-mean)*(k-4)) >> 2)
  - Intermediate width DATA_W+3; floor rounding. k=0 gives min, k=4 gives mean, k=8 gives max.
- DONE: thresh_valid=1; outputs stable; thresh_valid&thresh_ready -> IDLE.
- start outside IDLE is ignored. clear in any state -> IDLE, drops thresh_valid and overflow, discards partial sums.
- count is never 0 entering DIVIDE, so no divide-by-zero path exists.

## Timing
- Reset: state IDLE; tile_ready, thresh_valid, overflow = 0; threshold, tile_count = 0.
- start at edge E0 -> tile_ready=1 after E0.
- Last beat accepted at edge E -> tile_ready=0 after E. thresh_valid rises after edge E + CHANNELS*SUM_W + 1.
- tile_ready is deasserted the cycle after the terminating beat; no beat is ever dropped or double-counted.
- thresh_valid, threshold, tile_count and overflow stay constant while thresh_valid&!thresh_ready.
- Accept at edge A -> IDLE after A; a start in the cycle after A is honoured.
- Asynchronous reset mid-run: immediate return to reset values; no partial result is emitted.

## Structure
- Shared package holds the state enum, the ratio saturation constant (8), and a clog2-based CNT_W/SUM_W helper.
- One sub-module: seq_divider (SUM_W-bit restoring unsigned divider with start/busy/done), instantiated once and time-shared across channels.

## Test plan
- DATA_W=16, CHANNELS=2, MAX_TILES=8 (SUM_W=20). ch0 scores 10,20,30,40 and ch1 scores 5,5,5,5, ratio=4 -> thresholds 25/5, tile_count=4, thresh_valid 41 cycles after the last beat.
- Same data, ratio=2 -> ch0 17; ratio=6 -> ch0 32; ratio=0 -> 10; ratio=8 -> 40; ratio=15 -> 40 (saturated).
- Eight beats without tile_last -> run closes after the 8th beat, overflow=1, tile_count=8, tile_ready low afterwards.
- Random tile_valid gaps plus thresh_ready held low 10 cycles -> identical results; outputs stable while stalled; a start during the stall is ignored.
- clear asserted mid-ACCUM and mid-DIVIDE -> IDLE next cycle, thresh_valid never rises; the following run is computed from fresh accumulators.
- rst_n pulsed low in DONE -> all outputs 0 immediately; a single-beat run with score 0xFFFF afterwards gives min=max=mean=threshold=0xFFFF for every ratio.

Source files
------------

// File: rtl/block_threshold_unit_pkg.sv
// Shared types and sizing helpers for the block-pruning threshold unit.
// Imported by the top level of the unit.
package block_threshold_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_INTERP,
        S_DONE
    } state_e;

    // Pruning ratio is in eighths; 8 means "threshold at max"
    localparam logic [3:0] RATIO_MAX = 4'd8;

    function automatic int calc_cnt_w(input int max_tiles);
        return $clog2(max_tiles + 1);
    endfunction

    function automatic int calc_sum_w(input int data_w, input int max_tiles);
        return data_w + calc_cnt_w(max_tiles);
    endfunction

endpackage

// File: rtl/block_threshold_unit_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The first bit is produced on the start edge, the last on edge W.
module block_threshold_unit_seq_divider #(
    parameter int W     = 20,
    parameter int DW    = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [W-1:0]     dividend_i,
    input  logic [DW-1:0]    divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [OUT_W-1:0] quotient_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [DW-1:0] dvs_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W-1:0]  rem_src, quo_src;
    logic [DW-1:0] dvs_src;
    logic [W:0]    shifted;
    logic          take;

    // One restoring step, on fresh operands at start or on the running state
    always_comb begin
        rem_src = start_i ? '0 : rem_q;
        quo_src = start_i ? dividend_i : quo_q;
        dvs_src = start_i ? divisor_i : dvs_q;
        shifted = {rem_src, quo_src[W-1]};
        take    = shifted >= (W+1)'(dvs_src);
        rem_d   = take ? W'(shifted - (W+1)'(dvs_src)) : shifted[W-1:0];
        quo_d   = {quo_src[W-2:0], take};
    end

    // Iteration state; clear aborts any division in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_src;
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CW'(W - 1));
    assign quotient_o = quo_d[OUT_W-1:0];

endmodule

// File: rtl/block_threshold_unit.sv
// Per-channel min/mean/max accumulation and ratio-interpolated
// block-pruning threshold, one shared divider for all channels.
module block_threshold_unit
    import block_threshold_unit_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int CHANNELS  = 2,
    parameter int MAX_TILES = 64,
    localparam int CNT_W    = calc_cnt_w(MAX_TILES),
    localparam int SUM_W    = calc_sum_w(DATA_W, MAX_TILES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [3:0]                 ratio,
    input  logic                       clear,
    input  logic                       tile_valid,
    output logic                       tile_ready,
    input  logic                       tile_last,
    input  logic [CHANNELS*DATA_W-1:0] tile_score,
    output logic                       thresh_valid,
    input  logic                       thresh_ready,
    output logic [CHANNELS*DATA_W-1:0] threshold,
    output logic [CNT_W-1:0]           tile_count,
    output logic                       overflow
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IW   = DATA_W + 3;

    if (FRAC_BITS > DATA_W) begin : g_frac_chk
        $error("FRAC_BITS must not exceed DATA_W");
    end

    state_e            state_q;
    logic [3:0]        ratio_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic [CH_W-1:0]   chan_q;
    logic              ovf_q, tready_q, tvalid_q;
    logic [DATA_W-1:0] min_q  [CHANNELS];
    logic [DATA_W-1:0] max_q  [CHANNELS];
    logic [SUM_W-1:0]  sum_q  [CHANNELS];
    logic [DATA_W-1:0] mean_q [CHANNELS];
    logic [DATA_W-1:0] thr_q  [CHANNELS];
    logic [DATA_W-1:0] thr_d  [CHANNELS];
    logic [DATA_W-1:0] score  [CHANNELS];
    logic              beat, div_start, div_busy, div_done;
    logic [DATA_W-1:0] div_quo;

    assign beat      = tile_valid && tready_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign div_start = (state_q == S_DIVIDE) && !div_busy;

    // Unpack the per-channel score lanes and pack the thresholds back
    always_comb begin
        threshold = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            score[c] = tile_score[c*DATA_W +: DATA_W];
            threshold[c*DATA_W +: DATA_W] = thr_q[c];
        end
    end

    // Eighth-step interpolation: below 4 between min and mean, above between mean and max
    always_comb begin
        logic [IW-1:0]     span, k_ext, prod;
        logic [DATA_W-1:0] base;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ratio_q <= 4'd4) begin
                span  = IW'(mean_q[c] - min_q[c]);
                k_ext = IW'(ratio_q);
                base  = min_q[c];
            end else begin
                span  = IW'(max_q[c] - mean_q[c]);
                k_ext = IW'(ratio_q - 4'd4);
                base  = mean_q[c];
            end
            prod     = span * k_ext;
            thr_d[c] = base + DATA_W'(prod >> 2);
        end
    end

    block_threshold_unit_seq_divider #(
        .W     (SUM_W),
        .DW    (CNT_W),
        .OUT_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .start_i    (div_start),
        .dividend_i (sum_q[chan_q]),
        .divisor_i  (cnt_q),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    // Run sequencer with accumulators and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ratio_q  <= '0;
            cnt_q    <= '0;
            chan_q   <= '0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                min_q[c]  <= '0;
                max_q[c]  <= '0;
                sum_q[c]  <= '0;
                mean_q[c] <= '0;
                thr_q[c]  <= '0;
            end
        end else if (clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_ACCUM;
                        tready_q <= 1'b1;
                        ratio_q  <= (ratio > RATIO_MAX) ? RATIO_MAX : ratio;
                        cnt_q    <= '0;
                        ovf_q    <= 1'b0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            min_q[c] <= '1;
                            max_q[c] <= '0;
                            sum_q[c] <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            if (score[c] < min_q[c]) min_q[c] <= score[c];
                            if (score[c] > max_q[c]) max_q[c] <= score[c];
                            sum_q[c] <= sum_q[c] + SUM_W'(score[c]);
                        end
                        cnt_q <= cnt_inc;
                        if (tile_last || cnt_inc == CNT_W'(MAX_TILES)) begin
                            state_q  <= S_DIVIDE;
                            tready_q <= 1'b0;
                            ovf_q    <= !tile_last;
                            chan_q   <= '0;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (div_done) begin
                        mean_q[chan_q] <= div_quo;
                        if (chan_q == CH_W'(CHANNELS - 1)) begin
                            state_q <= S_INTERP;
                        end else begin
                            chan_q <= chan_q + CH_W'(1);
                        end
                    end
                end
                S_INTERP: begin
                    thr_q    <= thr_d;
                    state_q  <= S_DONE;
                    tvalid_q <= 1'b1;
                end
                S_DONE: begin
                    if (thresh_ready) begin
                        state_q  <= S_IDLE;
                        tvalid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tile_ready   = tready_q;
    assign thresh_valid = tvalid_q;
    assign tile_count   = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_block_threshold_unit.sv
// Directed scoreboard bench for block_threshold_unit.
// Expected thresholds are hand-derived constants queued per run.
module tb_block_threshold_unit;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int MT = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    ratio = '0;
    logic          clear = 1'b0;
    logic          tile_valid = 1'b0;
    logic          tile_ready;
    logic          tile_last = 1'b0;
    logic [CH*DW-1:0] tile_score = '0;
    logic          thresh_valid;
    logic          thresh_ready = 1'b0;
    logic [CH*DW-1:0] threshold;
    logic [CW-1:0] tile_count;
    logic          overflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] t0;
        logic [15:0] t1;
        logic [3:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] d0 [8];
    logic [15:0] d1 [8];

    always #5 clk = ~clk;

    block_threshold_unit #(
        .DATA_W    (DW),
        .FRAC_BITS (8),
        .CHANNELS  (CH),
        .MAX_TILES (MT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ratio        (ratio),
        .clear        (clear),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_last    (tile_last),
        .tile_score   (tile_score),
        .thresh_valid (thresh_valid),
        .thresh_ready (thresh_ready),
        .threshold    (threshold),
        .tile_count   (tile_count),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] r);
        start = 1'b1;
        ratio = r;
        tick();
        start = 1'b0;
        chk("start_ready", 32'(tile_ready), 1);
    endtask

    task automatic send_beats(input int n, input bit lastf, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int waited;
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            tile_valid = 1'b1;
            tile_score = {d1[i], d0[i]};
            tile_last  = lastf && (i == n - 1);
            waited = 0;
            while (!tile_ready && waited < 20) begin
                tick();
                waited++;
            end
            if (waited == 20) chk("beat_timeout", 32'(tile_ready), 1);
            tick();
            tile_valid = 1'b0;
            tile_last  = 1'b0;
        end
    endtask

    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!thresh_valid && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(thresh_valid), 1);
        chk({tag, "_latency"}, n, 41);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_thr0"}, 32'(threshold[15:0]), 32'(e.t0));
            chk({tag, "_thr1"}, 32'(threshold[31:16]), 32'(e.t1));
            chk({tag, "_count"}, 32'(tile_count), 32'(e.cnt));
            chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    task automatic accept();
        thresh_ready = 1'b1;
        tick();
        thresh_ready = 1'b0;
        chk("accept_drop", 32'(thresh_valid), 0);
    endtask

    task automatic run(input string tag, input logic [3:0] r, input int n,
                       input bit lastf, input bit gaps,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [3:0] ecnt, input logic eovf);
        exp_t e;
        do_start(r);
        e.t0 = e0; e.t1 = e1; e.cnt = ecnt; e.ovf = eovf;
        sb.push_back(e);
        send_beats(n, lastf, gaps);
        chk({tag, "_ready_low"}, 32'(tile_ready), 0);
        wait_result(tag);
        accept();
    endtask

    initial begin
        logic [3:0]  ratios [5];
        logic [15:0] exp0 [5];
        logic [3:0]  fr [5];
        bit          seen;

        // Reset values
        repeat (2) tick();
        chk("rst_tile_ready", 32'(tile_ready), 0);
        chk("rst_thresh_valid", 32'(thresh_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_threshold", threshold, 0);
        chk("rst_tile_count", 32'(tile_count), 0);
        rst_n = 1'b1;
        tick();

        // Basic run, ratio 4 gives the mean
        d0 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0};
        d1 = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        run("r4", 4'd4, 4, 1'b1, 1'b0, 16'd25, 16'd5, 4'd4, 1'b0);

        // Other ratios on the same data, including saturation of 15
        ratios = '{4'd2, 4'd6, 4'd0, 4'd8, 4'd15};
        exp0   = '{16'd17, 16'd32, 16'd10, 16'd40, 16'd40};
        for (int i = 0; i < 5; i++) begin
            run($sformatf("ratio%0d", ratios[i]), ratios[i], 4, 1'b1, 1'b0,
                exp0[i], 16'd5, 4'd4, 1'b0);
        end

        // Eight beats without tile_last close the run with overflow
        for (int i = 0; i < 8; i++) begin
            d0[i] = 16'(100 * (i + 1));
            d1[i] = 16'd7;
        end
        run("ovf", 4'd3, 8, 1'b0, 1'b0, 16'd362, 16'd7, 4'd8, 1'b1);

        // Gapped input and a stalled consumer with a start during the stall
        d0 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0};
        d1 = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(4'd6);
        sb.push_back('{16'd32, 16'd5, 4'd4, 1'b0});
        send_beats(4, 1'b1, 1'b1);
        wait_result("gap");
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            ratio = 4'd0;
            tick();
            chk("stall_valid", 32'(thresh_valid), 1);
            chk("stall_thr", threshold, {16'd5, 16'd32});
            chk("stall_count", 32'(tile_count), 4);
        end
        start = 1'b0;
        accept();
        tick();
        chk("stall_start_ignored", 32'(tile_ready), 0);

        // Clear in ACCUM with extreme scores that would poison later runs
        d0 = '{16'd1, 16'hF000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        d1 = '{16'd1, 16'hF000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(4'd4);
        send_beats(2, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_acc_ready", 32'(tile_ready), 0);
        chk("clr_acc_valid", 32'(thresh_valid), 0);

        // Clear in DIVIDE
        do_start(4'd4);
        send_beats(2, 1'b1, 1'b0);
        repeat (10) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_div_ready", 32'(tile_ready), 0);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (thresh_valid) seen = 1'b1;
        end
        chk("clr_div_no_valid", 32'(seen), 0);

        // Fresh run after the aborts, odd sum checks floor of the mean
        d0 = '{16'd3, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        d1 = '{16'd100, 16'd51, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        run("fresh", 4'd7, 2, 1'b1, 1'b0, 16'd7, 16'd93, 4'd2, 1'b0);

        // Asynchronous reset while a result is waiting
        d0 = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0};
        d1 = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0};
        do_start(4'd4);
        send_beats(4, 1'b1, 1'b0);
        for (int i = 0; i < 200 && !thresh_valid; i++) tick();
        chk("pre_rst_valid", 32'(thresh_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tile_ready", 32'(tile_ready), 0);
        chk("arst_thresh_valid", 32'(thresh_valid), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_threshold", threshold, 0);
        chk("arst_tile_count", 32'(tile_count), 0);
        #1 rst_n = 1'b1;
        tick();

        // Full-scale single beat: every ratio lands on 0xFFFF
        d0[0] = 16'hFFFF;
        d1[0] = 16'hFFFF;
        fr = '{4'd0, 4'd3, 4'd5, 4'd8, 4'd12};
        for (int i = 0; i < 5; i++) begin
            run($sformatf("full%0d", fr[i]), fr[i], 1, 1'b1, 1'b0,
                16'hFFFF, 16'hFFFF, 4'd1, 1'b0);
        end

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
